vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter STOCK_INIT, 8, per-slot stock loaded at reset and on restock (max 15).
REQ-002 SHALL have parameter MOTOR_TIMEOUT, 255, cycles allowed for motor_done after motor_req rises.
REQ-003 SHALL have parameter PRICE0/1/2/3, 50/65/75/100, slot prices in cents (multiples of 5, max 125).
REQ-004 SHALL have port: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: credit  in  7  current accumulated credit in cents.
REQ-006 SHALL have port: credit_clear  out  1  one-cycle pulse that zeroes the accumulator.
REQ-007 SHALL have port: sel_valid  in  1, sel_slot  in  2  purchase request and slot.
REQ-008 SHALL have port: restock  in  1, restock_slot  in  2  reload request and slot.
REQ-009 SHALL have port: motor_req  out  1, motor_slot  out  2, motor_done  in  1  vend-motor handshake.
REQ-010 SHALL have port: eject_req  out  1, eject_coin  out  2 (01=5, 10=10, 11=25), eject_ack  in  1  change-ejector handshake.
REQ-011 SHALL have port: busy  out  1, deny  out  1, fault  out  1, sold_out  out  4.

Function
REQ-012 SHALL implement states IDLE, CHECK, VEND, CHANGE, CLEAR, FAULT.
REQ-013 IDLE: sel_valid=1 SHALL latch sel_slot and credit and go to CHECK next cycle; busy=0 only in IDLE.
REQ-014 CHECK: stock==0 or latched credit < price SHALL pulse deny one cycle, return to IDLE, no credit_clear.
REQ-015 CHECK pass SHALL latch change = credit - price and enter VEND.
REQ-016 VEND: motor_req=1, motor_slot=latched slot, held until motor_done sampled high; then motor_req=0 next cycle, slot stock decremented by 1, go to CHANGE.
REQ-017 VEND: no motor_done within MOTOR_TIMEOUT cycles SHALL enter FAULT; stock unchanged.
REQ-018 FAULT: fault set sticky (cleared only by reset), change = full latched credit, then CHANGE.
REQ-019 CHANGE: greedy order 25, 10, 5; one coin per handshake; eject_req and eject_coin stable until eject_ack sampled high; eject_req low exactly one cycle between coins.
REQ-020 CHANGE: remaining change 0 (or residue <5, discarded) SHALL go to CLEAR.
REQ-021 CLEAR: credit_clear=1 for exactly one cycle, then IDLE.
REQ-022 Credit changes after latching SHALL be ignored; sel_valid outside IDLE SHALL be ignored.
REQ-023 restock in IDLE SHALL set stock[restock_slot]=STOCK_INIT; restock outside IDLE ignored; restock and sel_valid same cycle: restock wins, sel_valid dropped.
REQ-024 sold_out[i] SHALL equal (stock[i]==0) combinationally from the stock registers.
REQ-025 Subtraction SHALL be 7-bit unsigned; no underflow since CHECK guarantees credit >= price.

Reset
REQ-026 reset SHALL force IDLE; motor_req, eject_req, credit_clear, deny, fault, busy=0; eject_coin, motor_slot=0; all stock=STOCK_INIT; timeout counter and change register=0.
REQ-027 reset mid-VEND or mid-CHANGE SHALL abandon the transaction without credit_clear or stock decrement.

Structure
REQ-028 Package vend_pkg SHALL hold the state enum, coin-code typedef, and price constants.
REQ-029 Greedy coin ejection and its handshake SHALL be sub-module change_sequencer (start, amount in, done out).

Verification
REQ-030 credit=75, select slot 1 (65), motor_done after 3 cycles -> one 10 coin ejected, credit_clear pulse, stock1 7.
REQ-031 credit=40, select slot 0 -> deny one cycle, no motor_req, no credit_clear.
REQ-032 credit=125, slot 0 -> ejects 25,25,25 (75), eject_ack delayed 4 cycles each, req held stable.
REQ-033 motor_done never asserted -> FAULT after 255 cycles, fault=1, full 100 refunded as 25x4, stock unchanged.
REQ-034 slot 2 vended 8 times -> sold_out[2]=1, ninth select denied; restock slot 2 -> sold_out[2]=0.
REQ-035 reset asserted during CHANGE -> all outputs 0 immediately, stock=8, next select processed normally.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, default prices and coin helpers for the vending controller
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_VEND   = 3'd2,
        S_CHANGE = 3'd3,
        S_CLEAR  = 3'd4,
        S_FAULT  = 3'd5
    } vend_state_t;

    typedef enum logic [1:0] {
        SQ_IDLE  = 2'd0,
        SQ_GAP   = 2'd1,
        SQ_ISSUE = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } coin_t;

    localparam int PRICE0_DEF = 50;
    localparam int PRICE1_DEF = 65;
    localparam int PRICE2_DEF = 75;
    localparam int PRICE3_DEF = 100;

    // Largest coin that fits; COIN_NONE means the remainder is a discarded residue.
    function automatic coin_t coin_pick(input logic [6:0] amt);
        if (amt >= 7'd25)      return COIN_25;
        else if (amt >= 7'd10) return COIN_10;
        else if (amt >= 7'd5)  return COIN_5;
        else                   return COIN_NONE;
    endfunction

    function automatic logic [6:0] coin_value(input coin_t c);
        case (c)
            COIN_25: return 7'd25;
            COIN_10: return 7'd10;
            COIN_5:  return 7'd5;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_sequencer.sv
// rtl/change_sequencer.sv - greedy 25/10/5 coin ejection with a req/ack handshake
module change_sequencer
    import vend_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       eject_ack,
    output logic       eject_req,
    output logic [1:0] eject_coin,
    output logic       done
);

    seq_state_t r_state, w_state_nxt;
    logic [6:0] r_rem, w_rem_nxt;
    coin_t      r_coin, w_coin_nxt;
    coin_t      w_pick;

    assign w_pick = coin_pick(r_rem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SQ_IDLE;
            r_rem   <= 7'd0;
            r_coin  <= COIN_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_coin  <= w_coin_nxt;
        end
    end

    // SQ_GAP lasts one cycle, which gives the single low cycle between coins.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_coin_nxt  = r_coin;
        done        = 1'b0;
        case (r_state)
            SQ_IDLE: begin
                if (start) begin
                    w_rem_nxt   = amount;
                    w_state_nxt = SQ_GAP;
                end
            end
            SQ_GAP: begin
                if (w_pick == COIN_NONE) begin
                    done        = 1'b1;
                    w_state_nxt = SQ_IDLE;
                end else begin
                    w_coin_nxt  = w_pick;
                    w_state_nxt = SQ_ISSUE;
                end
            end
            SQ_ISSUE: begin
                if (eject_ack) begin
                    w_rem_nxt   = r_rem - coin_value(r_coin);
                    w_coin_nxt  = COIN_NONE;
                    w_state_nxt = SQ_GAP;
                end
            end
            default: w_state_nxt = SQ_IDLE;
        endcase
    end

    assign eject_req  = (r_state == SQ_ISSUE);
    assign eject_coin = r_coin;

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - four-slot vending controller: price check, motor handshake, change, credit clear
module vend_controller
    import vend_pkg::*;
#(
    parameter int STOCK_INIT    = 8,
    parameter int MOTOR_TIMEOUT = 255,
    parameter int PRICE0        = PRICE0_DEF,
    parameter int PRICE1        = PRICE1_DEF,
    parameter int PRICE2        = PRICE2_DEF,
    parameter int PRICE3        = PRICE3_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] credit,
    output logic       credit_clear,
    input  logic       sel_valid,
    input  logic [1:0] sel_slot,
    input  logic       restock,
    input  logic [1:0] restock_slot,
    output logic       motor_req,
    output logic [1:0] motor_slot,
    input  logic       motor_done,
    output logic       eject_req,
    output logic [1:0] eject_coin,
    input  logic       eject_ack,
    output logic       busy,
    output logic       deny,
    output logic       fault,
    output logic [3:0] sold_out
);

    localparam int          TW       = $clog2(MOTOR_TIMEOUT + 1);
    localparam logic [3:0]  STOCK_LD = 4'(STOCK_INIT);

    vend_state_t   r_state, w_next;
    logic [1:0]    r_slot;
    logic [6:0]    r_credit;
    logic [6:0]    r_change;
    logic [TW-1:0] r_tmo;
    logic          r_fault;
    logic [3:0]    r_stock [4];

    logic [6:0]    w_price;
    logic          w_fail;
    logic          w_timeout;
    logic          w_seq_start;
    logic          w_seq_done;

    always_comb begin
        w_price = 7'(PRICE0);
        case (r_slot)
            2'd0: w_price = 7'(PRICE0);
            2'd1: w_price = 7'(PRICE1);
            2'd2: w_price = 7'(PRICE2);
            2'd3: w_price = 7'(PRICE3);
            default: w_price = 7'(PRICE0);
        endcase
    end

    assign w_fail    = (r_stock[r_slot] == 4'd0) || (r_credit < w_price);
    assign w_timeout = (r_tmo == TW'(MOTOR_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_slot   <= 2'd0;
            r_credit <= 7'd0;
            r_change <= 7'd0;
            r_tmo    <= '0;
            r_fault  <= 1'b0;
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_LD;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (restock) begin
                        r_stock[restock_slot] <= STOCK_LD;
                    end else if (sel_valid) begin
                        r_slot   <= sel_slot;
                        r_credit <= credit;
                    end
                end
                S_CHECK: begin
                    if (!w_fail) begin
                        r_change <= r_credit - w_price;
                        r_tmo    <= '0;
                    end
                end
                S_VEND: begin
                    if (motor_done) begin
                        r_stock[r_slot] <= r_stock[r_slot] - 4'd1;
                    end else if (w_timeout) begin
                        r_change <= r_credit;
                        r_fault  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The sequencer is kicked on the edge that enters CHANGE, so r_change is already final.
    always_comb begin
        w_next       = r_state;
        w_seq_start  = 1'b0;
        deny         = 1'b0;
        motor_req    = 1'b0;
        motor_slot   = 2'd0;
        credit_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!restock && sel_valid) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_fail) begin
                    deny   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_VEND;
                end
            end
            S_VEND: begin
                motor_req  = 1'b1;
                motor_slot = r_slot;
                if (motor_done) begin
                    w_next      = S_CHANGE;
                    w_seq_start = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_FAULT: begin
                w_next      = S_CHANGE;
                w_seq_start = 1'b1;
            end
            S_CHANGE: begin
                if (w_seq_done) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                credit_clear = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        sold_out = 4'd0;
        for (int i = 0; i < 4; i++) sold_out[i] = (r_stock[i] == 4'd0);
    end

    assign busy  = (r_state != S_IDLE);
    assign fault = r_fault;

    change_sequencer u_change (
        .clk        (clk),
        .reset      (reset),
        .start      (w_seq_start),
        .amount     (r_change),
        .eject_ack  (eject_ack),
        .eject_req  (eject_req),
        .eject_coin (eject_coin),
        .done       (w_seq_done)
    );

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] credit;
    logic       credit_clear;
    logic       sel_valid;
    logic [1:0] sel_slot;
    logic       restock;
    logic [1:0] restock_slot;
    logic       motor_req;
    logic [1:0] motor_slot;
    logic       motor_done;
    logic       eject_req;
    logic [1:0] eject_coin;
    logic       eject_ack;
    logic       busy;
    logic       deny;
    logic       fault;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_errors = 0;

    int         res_deny, res_motor, res_clear;
    int         res_gap_bad, res_stable_bad, res_mslot_bad, res_timeout;
    logic [1:0] res_coins [$];

    always #5 clk = ~clk;

    vend_controller dut (
        .clk          (clk),
        .reset        (reset),
        .credit       (credit),
        .credit_clear (credit_clear),
        .sel_valid    (sel_valid),
        .sel_slot     (sel_slot),
        .restock      (restock),
        .restock_slot (restock_slot),
        .motor_req    (motor_req),
        .motor_slot   (motor_slot),
        .motor_done   (motor_done),
        .eject_req    (eject_req),
        .eject_coin   (eject_coin),
        .eject_ack    (eject_ack),
        .busy         (busy),
        .deny         (deny),
        .fault        (fault),
        .sold_out     (sold_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // exp packs coin codes two bits each, first coin in bits [1:0].
    task automatic check_coins(input string tag, input int n, input logic [7:0] exp);
        logic [7:0] e;
        e = exp;
        check({tag, "_ncoins"}, res_coins.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < res_coins.size()) check($sformatf("%s_coin%0d", tag, i), res_coins[i], e[1:0]);
            e = e >> 2;
        end
    endtask

    // One purchase: select, then act as motor and ejector until the controller is idle again.
    // md < 0 means the motor never reports done.
    task automatic run_txn(input logic [1:0] slot, input logic [6:0] cr, input int md, input int ad);
        int         mcnt, acnt, gap, cyc;
        logic       in_req;
        logic [1:0] cur_coin;
        res_deny = 0; res_motor = 0; res_clear = 0;
        res_gap_bad = 0; res_stable_bad = 0; res_mslot_bad = 0; res_timeout = 0;
        res_coins.delete();
        mcnt = 0; acnt = 0; gap = 0; cyc = 0; in_req = 1'b0; cur_coin = 2'd0;
        @(negedge clk);
        sel_slot  = slot;
        credit    = cr;
        sel_valid = 1'b1;
        @(posedge clk); #1;
        sel_valid = 1'b0;
        credit    = 7'd3;
        while (1) begin
            if (deny) res_deny++;
            if (credit_clear) res_clear++;
            if (motor_req) begin
                res_motor++;
                if (motor_slot !== slot) res_mslot_bad++;
                motor_done = (md >= 0) && (mcnt == md);
                mcnt++;
            end else begin
                motor_done = 1'b0;
            end
            if (eject_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    cur_coin = eject_coin;
                    acnt     = 0;
                    if (res_coins.size() > 0 && gap != 1) res_gap_bad++;
                end else if (eject_coin !== cur_coin) begin
                    res_stable_bad++;
                end
                if (acnt == ad) begin
                    eject_ack = 1'b1;
                    res_coins.push_back(cur_coin);
                end else begin
                    eject_ack = 1'b0;
                end
                acnt++;
            end else begin
                eject_ack = 1'b0;
                if (in_req) begin
                    in_req = 1'b0;
                    gap    = 0;
                end
                gap++;
            end
            if (!busy) break;
            if (cyc == 2000) begin
                res_timeout = 1;
                break;
            end
            cyc++;
            @(posedge clk); #1;
        end
        motor_done = 1'b0;
        eject_ack  = 1'b0;
    endtask

    task automatic do_restock(input logic [1:0] slot, input logic also_sel);
        @(negedge clk);
        restock      = 1'b1;
        restock_slot = slot;
        sel_valid    = also_sel;
        sel_slot     = 2'd0;
        credit       = 7'd100;
        @(posedge clk); #1;
        restock   = 1'b0;
        sel_valid = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; credit = 7'd0; sel_valid = 1'b0; sel_slot = 2'd0;
        restock = 1'b0; restock_slot = 2'd0; motor_done = 1'b0; eject_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_motor_req", motor_req, 0);
        check("rst_motor_slot", motor_slot, 0);
        check("rst_eject_req", eject_req, 0);
        check("rst_eject_coin", eject_coin, 0);
        check("rst_credit_clear", credit_clear, 0);
        check("rst_deny", deny, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        check("rst_sold_out", sold_out, 4'b0000);

        // credit 75, slot 1 (65): one 10 coin
        run_txn(2'd1, 7'd75, 3, 0);
        check("v1_timeout", res_timeout, 0);
        check("v1_deny", res_deny, 0);
        check("v1_motor_cycles", res_motor, 4);
        check("v1_motor_slot", res_mslot_bad, 0);
        check_coins("v1", 1, 8'b10);
        check("v1_clear", res_clear, 1);
        check("v1_stock1", dut.r_stock[1], 7);

        // credit 40, slot 0 (50): denied
        run_txn(2'd0, 7'd40, 3, 0);
        check("d1_deny", res_deny, 1);
        check("d1_motor", res_motor, 0);
        check("d1_clear", res_clear, 0);
        check_coins("d1", 0, 8'd0);

        // credit 125, slot 0: three 25s with slow ack
        run_txn(2'd0, 7'd125, 1, 4);
        check("c3_timeout", res_timeout, 0);
        check_coins("c3", 3, 8'b11_11_11);
        check("c3_stable", res_stable_bad, 0);
        check("c3_gap", res_gap_bad, 0);
        check("c3_clear", res_clear, 1);
        check("c3_stock0", dut.r_stock[0], 7);

        // exact credit, no change
        run_txn(2'd3, 7'd100, 0, 0);
        check_coins("ex", 0, 8'd0);
        check("ex_clear", res_clear, 1);
        check("ex_deny", res_deny, 0);

        // credit 57, slot 0: change 7 -> one 5, residue 2 discarded
        run_txn(2'd0, 7'd57, 0, 0);
        check_coins("rs", 1, 8'b01);
        check("rs_clear", res_clear, 1);

        // credit 115, slot 2 (75): change 40 -> 25,10,5
        run_txn(2'd2, 7'd115, 2, 1);
        check_coins("mx", 3, 8'b01_10_11);
        check("mx_gap", res_gap_bad, 0);
        check("mx_stock2", dut.r_stock[2], 7);

        // motor never answers: fault, full refund
        check("ft_fault_before", fault, 0);
        run_txn(2'd3, 7'd100, -1, 0);
        check("ft_timeout", res_timeout, 0);
        check("ft_motor_cycles", res_motor, 255);
        check("ft_fault", fault, 1);
        check_coins("ft", 4, 8'b11_11_11_11);
        check("ft_clear", res_clear, 1);
        check("ft_stock3", dut.r_stock[3], 7);

        // drain slot 2 then deny, then restock
        for (int i = 0; i < 7; i++) begin
            run_txn(2'd2, 7'd75, 0, 0);
            check($sformatf("so_iter%0d", i), sold_out[2], (i == 6) ? 1 : 0);
        end
        run_txn(2'd2, 7'd100, 0, 0);
        check("so_deny", res_deny, 1);
        check("so_motor", res_motor, 0);
        check("so_fault_sticky", fault, 1);
        do_restock(2'd2, 1'b1);
        check("rk_sel_dropped", busy, 0);
        check("rk_sold_out2", sold_out[2], 0);
        check("rk_stock2", dut.r_stock[2], 8);

        // reset while change is being ejected
        @(negedge clk);
        sel_slot = 2'd0; credit = 7'd125; sel_valid = 1'b1;
        @(posedge clk); #1;
        sel_valid = 1'b0;
        guard = 0;
        while (!eject_req && guard < 50) begin
            motor_done = motor_req;
            guard++;
            @(posedge clk); #1;
        end
        motor_done = 1'b0;
        check("rc_reached_change", eject_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rc_eject_req", eject_req, 0);
        check("rc_eject_coin", eject_coin, 0);
        check("rc_busy", busy, 0);
        check("rc_fault", fault, 0);
        check("rc_clear", credit_clear, 0);
        check("rc_sold_out", sold_out, 4'b0000);
        check("rc_stock0", dut.r_stock[0], 8);
        @(negedge clk);
        reset = 1'b0;
        run_txn(2'd1, 7'd75, 3, 0);
        check_coins("ra", 1, 8'b10);
        check("ra_clear", res_clear, 1);
        check("ra_stock1", dut.r_stock[1], 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
